// File: rtl/bit_permute_stream.sv
// Streaming bit-permutation stage: runtime map (double-buffered), per-word bypass,
// output register plus skid register behind a registered s_ready.
module bit_permute_stream #(
    parameter  int W  = 8,
    parameter  int CW = 16,
    localparam int IW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [W-1:0]  s_data,
    input  logic          s_bypass,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [W-1:0]  m_data,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [IW-1:0] cfg_src,
    input  logic          cfg_commit,
    output logic [CW-1:0] xfer_count
);

    logic [W-1:0][IW-1:0] shadow_map;
    logic [W-1:0][IW-1:0] active_map;

    logic [W-1:0]  out_data_p1;
    logic          out_vld_p1;
    logic [W-1:0]  skid_data_p1;
    logic          skid_vld_p1;
    logic          s_ready_q;
    logic [CW-1:0] count_q;

    logic          accept;
    logic          drain;
    logic          skid_vld_nxt;
    logic [W-1:0]  xform_p0;

    function automatic logic [W-1:0] permute(input logic [W-1:0] d,
                                             input logic [W-1:0][IW-1:0] map);
        logic [W-1:0] p;
        p = '0;
        for (int i = 0; i < W; i++) begin
            p[i] = d[map[i]];
        end
        return p;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign accept   = s_valid & s_ready_q;
    assign drain    = out_vld_p1 & m_ready;
    assign xform_p0 = s_bypass ? s_data : permute(s_data, active_map);

    // Commit copies the pre-edge shadow, so a same-cycle write lands only in the shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < W; i++) begin
                shadow_map[i] <= IW'(i);
                active_map[i] <= IW'(i);
            end
        end else begin
            if (cfg_commit) active_map <= shadow_map;
            if (cfg_we)     shadow_map[cfg_idx] <= cfg_src;
        end
    end

    always_comb begin
        skid_vld_nxt = skid_vld_p1;
        if (!out_vld_p1 || drain) skid_vld_nxt = 1'b0;
        else if (accept)          skid_vld_nxt = 1'b1;
    end

    // ---- stage p0 -> p1: OUT / SKID registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_p1  <= '0;
            out_vld_p1   <= 1'b0;
            skid_data_p1 <= '0;
            skid_vld_p1  <= 1'b0;
            s_ready_q    <= 1'b0;
            count_q      <= '0;
        end else begin
            if (!out_vld_p1 || drain) begin
                if (skid_vld_p1) begin
                    out_data_p1 <= skid_data_p1;
                    out_vld_p1  <= 1'b1;
                end else if (accept) begin
                    out_data_p1 <= xform_p0;
                    out_vld_p1  <= 1'b1;
                end else begin
                    out_vld_p1  <= 1'b0;
                end
            end else if (accept) begin
                skid_data_p1 <= xform_p0;
            end
            skid_vld_p1 <= skid_vld_nxt;
            s_ready_q   <= !skid_vld_nxt;
            if (drain) count_q <= sat_inc(count_q);
        end
    end

    assign s_ready    = s_ready_q;
    assign m_valid    = out_vld_p1;
    assign m_data     = out_data_p1;
    assign xfer_count = count_q;

endmodule

// File: tb/tb_bit_permute_stream.sv
// Self-checking bench for bit_permute_stream: directed scenarios plus random words
// scored against a map-level reference model.
module tb_bit_permute_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid, s_bypass, m_ready, cfg_we, cfg_commit;
    logic [7:0] s_data;
    logic [2:0] cfg_idx, cfg_src;
    logic       s_ready, m_valid;
    logic [7:0] m_data;
    logic [15:0] xfer_count;
    logic       s_ready4, m_valid4;
    logic [7:0] m_data4;
    logic [3:0] xfer4;

    int checks = 0;
    int passes = 0;

    int         ref_active[8];
    int         ref_shadow[8];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         ref_count;

    always #5 clk = ~clk;

    bit_permute_stream #(.W(8), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_bypass(s_bypass), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_src(cfg_src),
        .cfg_commit(cfg_commit), .xfer_count(xfer_count));

    bit_permute_stream #(.W(8), .CW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready4),
        .s_data(s_data), .s_bypass(s_bypass), .m_valid(m_valid4), .m_ready(m_ready),
        .m_data(m_data4), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_src(cfg_src),
        .cfg_commit(cfg_commit), .xfer_count(xfer4));

    function automatic logic [7:0] ref_perm(input logic [7:0] d, input int m[8]);
        int r = 0;
        for (int i = 0; i < 8; i++) r = r + (((int'(d) >> m[i]) & 1) << i);
        return 8'(r);
    endfunction

    // Reference model: maps, expected-word queue and drain log, updated per edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                ref_active[i] = i;
                ref_shadow[i] = i;
            end
            exp_q.delete();
            got_q.delete();
            ref_count = 0;
        end else begin
            if (s_valid && s_ready)
                exp_q.push_back(s_bypass ? s_data : ref_perm(s_data, ref_active));
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                ref_count = ref_count + 1;
            end
            if (cfg_commit) ref_active = ref_shadow;
            if (cfg_we)     ref_shadow[cfg_idx] = int'(cfg_src);
        end
    end

    task automatic idle_inputs();
        s_valid = 0; s_bypass = 0; s_data = 0; m_ready = 1;
        cfg_we = 0; cfg_idx = 0; cfg_src = 0; cfg_commit = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        #1;
        checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got %0b want 0", m_valid); else passes++;
        checks++; if (m_data !== 8'h00) $display("FAIL reset_m_data got %h want 00", m_data); else passes++;
        checks++; if (xfer_count !== 16'd0) $display("FAIL reset_count got %0d want 0", xfer_count); else passes++;
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready got %0b want 1", s_ready); else passes++;
    endtask

    task automatic test_basic();
        s_valid = 1; s_data = 8'hA5; s_bypass = 0; m_ready = 1;
        @(negedge clk); s_valid = 0;
        checks++; if (m_valid !== 1'b1 || m_data !== 8'hA5)
            $display("FAIL basic_word got v=%0b d=%h want v=1 d=a5", m_valid, m_data); else passes++;
        @(negedge clk);
        checks++; if (xfer_count !== 16'd1) $display("FAIL basic_count got %0d want 1", xfer_count); else passes++;
        checks++; if (m_valid !== 1'b0) $display("FAIL basic_empty got %0b want 0", m_valid); else passes++;
    endtask

    task automatic test_reverse();
        for (int i = 0; i < 8; i++) begin
            cfg_we = 1; cfg_idx = 3'(i); cfg_src = 3'(7 - i);
            @(negedge clk);
        end
        cfg_we = 0; cfg_commit = 1;
        @(negedge clk);
        cfg_commit = 0; s_valid = 1; s_data = 8'h12; s_bypass = 0;
        @(negedge clk);
        checks++; if (m_data !== 8'h48) $display("FAIL reverse_perm got %h want 48", m_data); else passes++;
        s_bypass = 1;
        @(negedge clk);
        checks++; if (m_data !== 8'h12) $display("FAIL reverse_bypass got %h want 12", m_data); else passes++;
        s_valid = 0; s_bypass = 0;
        @(negedge clk);
    endtask

    task automatic test_commit_midstream();
        int bg = got_q.size();
        int be = exp_q.size();
        logic [7:0] want;
        for (int c = 0; c < 13; c++) begin
            s_valid = 1; s_bypass = 0; s_data = (c == 12) ? 8'h01 : 8'h12;
            cfg_we = (c < 8); cfg_idx = 3'(c); cfg_src = (c == 7) ? 3'd0 : 3'(c + 1);
            cfg_commit = (c == 8);
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk); @(negedge clk);
        checks++; if (got_q.size() - bg != 13)
            $display("FAIL midstream_count got %0d want 13", got_q.size() - bg); else passes++;
        for (int k = 0; k < 13 && bg + k < got_q.size(); k++) begin
            want = (k <= 8) ? 8'h48 : ((k < 12) ? 8'h09 : 8'h80);
            checks++; if (got_q[bg+k] !== want)
                $display("FAIL midstream_word%0d got %h want %h", k, got_q[bg+k], want); else passes++;
            if (be + k < exp_q.size()) begin
                checks++; if (got_q[bg+k] !== exp_q[be+k])
                    $display("FAIL midstream_model%0d got %h want %h", k, got_q[bg+k], exp_q[be+k]); else passes++;
            end
        end
    endtask

    task automatic test_backpressure();
        int be = exp_q.size();
        m_ready = 0; s_valid = 1; s_bypass = 1; s_data = 8'd1;
        @(negedge clk); s_data = 8'd2;
        checks++; if (m_data !== 8'd1 || m_valid !== 1'b1)
            $display("FAIL bp_hold1 got v=%0b d=%h want v=1 d=01", m_valid, m_data); else passes++;
        @(negedge clk); s_data = 8'd3;
        checks++; if (s_ready !== 1'b0) $display("FAIL bp_s_ready got %0b want 0", s_ready); else passes++;
        @(negedge clk);
        checks++; if (m_data !== 8'd1 || m_valid !== 1'b1)
            $display("FAIL bp_hold3 got v=%0b d=%h want v=1 d=01", m_valid, m_data); else passes++;
        checks++; if (exp_q.size() - be != 2)
            $display("FAIL bp_accepted got %0d want 2", exp_q.size() - be); else passes++;
        m_ready = 1;
        @(negedge clk);
        checks++; if (m_data !== 8'd2 || m_valid !== 1'b1)
            $display("FAIL bp_word2 got v=%0b d=%h want v=1 d=02", m_valid, m_data); else passes++;
        @(negedge clk); s_valid = 0;
        checks++; if (m_data !== 8'd3 || m_valid !== 1'b1)
            $display("FAIL bp_word3 got v=%0b d=%h want v=1 d=03", m_valid, m_data); else passes++;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) $display("FAIL bp_drained got %0b want 0", m_valid); else passes++;
        s_bypass = 0;
    endtask

    task automatic test_async_reset();
        m_ready = 0; s_valid = 1; s_bypass = 0; s_data = 8'h12;
        @(negedge clk); @(negedge clk);
        s_valid = 0;
        checks++; if (s_ready !== 1'b0) $display("FAIL areset_full got %0b want 0", s_ready); else passes++;
        #2 rst_n = 0;
        #1;
        checks++; if (m_valid !== 1'b0) $display("FAIL areset_m_valid got %0b want 0", m_valid); else passes++;
        #1 rst_n = 1;
        m_ready = 1;
        @(negedge clk);
        checks++; if (xfer_count !== 16'd0) $display("FAIL areset_count got %0d want 0", xfer_count); else passes++;
        checks++; if (s_ready !== 1'b1 || m_valid !== 1'b0)
            $display("FAIL areset_state got r=%0b v=%0b want r=1 v=0", s_ready, m_valid); else passes++;
        s_valid = 1; s_data = 8'h12;
        @(negedge clk); s_valid = 0;
        checks++; if (m_data !== 8'h12) $display("FAIL areset_identity got %h want 12", m_data); else passes++;
        @(negedge clk);
    endtask

    task automatic test_random();
        int bg = got_q.size();
        int be = exp_q.size();
        for (int c = 0; c < 200; c++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data = 8'($urandom);
            s_bypass = ($urandom_range(0, 3) == 0);
            m_ready = ($urandom_range(0, 2) != 0);
            cfg_we = 1'($urandom_range(0, 1));
            cfg_idx = 3'($urandom); cfg_src = 3'($urandom);
            cfg_commit = ($urandom_range(0, 9) == 0);
            @(negedge clk);
        end
        idle_inputs();
        repeat (4) @(negedge clk);
        checks++; if (got_q.size() - bg != exp_q.size() - be)
            $display("FAIL random_count got %0d want %0d", got_q.size() - bg, exp_q.size() - be); else passes++;
        for (int k = 0; bg + k < got_q.size() && be + k < exp_q.size(); k++) begin
            checks++; if (got_q[bg+k] !== exp_q[be+k])
                $display("FAIL random_word%0d got %h want %h", k, got_q[bg+k], exp_q[be+k]); else passes++;
        end
        checks++; if (int'(xfer_count) != ref_count)
            $display("FAIL random_xfer got %0d want %0d", xfer_count, ref_count); else passes++;
    endtask

    task automatic test_saturation();
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            s_valid = 1; s_bypass = 1; m_ready = 1; s_data = 8'(c);
            @(negedge clk);
        end
        s_valid = 0;
        @(negedge clk); @(negedge clk);
        checks++; if (xfer4 !== 4'd15) $display("FAIL sat_cw4 got %0d want 15", xfer4); else passes++;
        checks++; if (xfer_count !== 16'd20) $display("FAIL sat_cw16 got %0d want 20", xfer_count); else passes++;
        repeat (3) @(negedge clk);
        checks++; if (xfer4 !== 4'd15) $display("FAIL sat_hold got %0d want 15", xfer4); else passes++;
    endtask

    task automatic test_same_cycle_cfg();
        cfg_we = 1; cfg_idx = 3'd0; cfg_src = 3'd1; cfg_commit = 1;
        @(negedge clk);
        cfg_we = 0; cfg_commit = 0; s_valid = 1; s_bypass = 0; s_data = 8'h02;
        @(negedge clk); s_valid = 0; cfg_commit = 1;
        checks++; if (m_data !== 8'h02) $display("FAIL samecyc_old got %h want 02", m_data); else passes++;
        @(negedge clk); cfg_commit = 0; s_valid = 1; s_data = 8'h02;
        @(negedge clk); s_valid = 0;
        checks++; if (m_data !== 8'h03) $display("FAIL samecyc_new got %h want 03", m_data); else passes++;
        checks++; if (m_data4 !== 8'h03 || m_valid4 !== 1'b1 || s_ready4 !== 1'b1)
            $display("FAIL samecyc_cw4 got d=%h v=%0b r=%0b want d=03 v=1 r=1", m_data4, m_valid4, s_ready4); else passes++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reverse();
        test_commit_midstream();
        test_backpressure();
        test_async_reset();
        test_random();
        test_saturation();
        test_same_cycle_cfg();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
